// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - opcode encodings, FSM states and op-class helper for the mdu sequencer
// MADD/MADDU join the mult/div class only when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_md_class(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    return 1'b1;
`endif
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - E/D-stage handshake and HI/LO result bundle for the mdu sequencer
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_use_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, d_use_md,
                  input  busy, stall, hi, lo);
  modport slave  (input  start, op, a, b, d_use_md,
                  output busy, stall, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit {hi,lo} result for a mult/div/madd op
// MADD/MADDU datapath present only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] q_s, r_s;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign q_s    = $signed(a) / $signed(b);
  assign r_s    = $signed(a) % $signed(b);

  // A zero divisor keeps the current {hi,lo}, so the commit is a no-op.
  always_comb begin
    res = {hi, lo};
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV: begin
        if (b == 32'd0)
          res = {hi, lo};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          res = {32'd0, 32'h8000_0000};
        else
          res = {r_s, q_s};
      end
      MDU_DIVU: begin
        if (b != 32'd0)
          res = {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  res = {hi, lo} + prod_s;
      MDU_MADDU: res = {hi, lo} + prod_u;
`endif
      default:   res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle mult/div sequencer owning HI/LO, busy countdown and D-stage stall
// Optional MADD/MADDU support via MDU_MADD_EN.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  mdu_state_e  state;
  logic [CW-1:0] cnt;
  logic        busy_r;
  logic [31:0] hi_r, lo_r;
  logic [31:0] pend_hi, pend_lo;
  logic [63:0] res;
  logic        md_start;
  logic        is_div;

  mdu_arith u_arith (
    .op  (bus.op),
    .a   (bus.a),
    .b   (bus.b),
    .hi  (hi_r),
    .lo  (lo_r),
    .res (res)
  );

  assign md_start = bus.start & is_md_class(bus.op);
  assign is_div   = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);

  // Result is captured at the start edge; HI/LO only change at commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_r  <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state   <= RUN;
            busy_r  <= 1'b1;
            cnt     <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            pend_hi <= res[63:32];
            pend_lo <= res[31:0];
          end else if (bus.start && bus.op == MDU_MTHI) begin
            hi_r <= bus.a;
          end else if (bus.start && bus.op == MDU_MTLO) begin
            lo_r <= bus.a;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            hi_r   <= pend_hi;
            lo_r   <= pend_lo;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.stall = bus.d_use_md & (busy_r | md_start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
// MADD vectors switch with MDU_MADD_EN.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mdu_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && bus.start && bus.busy) begin
      fails++;
      $display("FAIL start_while_busy: start=%0b busy=%0b required busy=0", bus.start, bus.busy);
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      fails++; $display("FAIL reset_busy: busy=%0b stall=%0b required 0 0", bus.busy, bus.stall);
    end
    tests++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      fails++; $display("FAIL reset_hilo: hi=%h lo=%h required 0 0", bus.hi, bus.lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    int n;
    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5, n);
    tests++;
    if (n !== 5) begin fails++; $display("FAIL mult_busy_cycles: got %0d required 5", n); end
    tests++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      fails++; $display("FAIL mult_result: hi=%h lo=%h required ffffffff fffffff1", bus.hi, bus.lo);
    end
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    tests++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      fails++; $display("FAIL multu_result: hi=%h lo=%h required fffffffe 00000001", bus.hi, bus.lo);
    end
    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    tests++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd1) begin
      fails++; $display("FAIL mult_neg_neg: hi=%h lo=%h required 0 1", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div;
    int n;
    run_op(MDU_DIVU, 32'd7, 32'd2, n);
    tests++;
    if (n !== 10) begin fails++; $display("FAIL divu_busy_cycles: got %0d required 10", n); end
    tests++;
    if (bus.lo !== 32'd3 || bus.hi !== 32'd1) begin
      fails++; $display("FAIL divu_result: hi=%h lo=%h required 1 3", bus.hi, bus.lo);
    end
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
    tests++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL div_signed: hi=%h lo=%h required ffffffff fffffffd", bus.hi, bus.lo);
    end
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    tests++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
      fails++; $display("FAIL div_overflow: hi=%h lo=%h required 0 80000000", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_zero;
    int n;
    move_to(MDU_MTHI, 32'h11);
    move_to(MDU_MTLO, 32'h22);
    run_op(MDU_DIV, 32'd100, 32'd0, n);
    tests++;
    if (n !== 10) begin fails++; $display("FAIL divzero_busy_cycles: got %0d required 10", n); end
    tests++;
    if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
      fails++; $display("FAIL divzero_hilo: hi=%h lo=%h required 11 22", bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid_op;
    move_to(MDU_MTHI, 32'h55);
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      fails++; $display("FAIL reset_mid_op: busy=%0b hi=%h lo=%h required 0 0 0", bus.busy, bus.hi, bus.lo);
    end
    repeat (8) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      fails++; $display("FAIL no_late_commit: busy=%0b hi=%h lo=%h required 0 0 0", bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_stall;
    int hi_cnt;
    int busy_cnt;
    bus.d_use_md = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd6; bus.b = 32'd7;
    #1;
    tests++;
    if (bus.stall !== 1'b1) begin fails++; $display("FAIL stall_start_cycle: got %0b required 1", bus.stall); end
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    hi_cnt = 0; busy_cnt = 0;
    while (bus.busy && busy_cnt < 100) begin
      busy_cnt++;
      if (bus.stall === 1'b1) hi_cnt++;
      @(negedge clk);
    end
    tests++;
    if (hi_cnt !== 5 || busy_cnt !== 5) begin
      fails++; $display("FAIL stall_busy_cycles: stall=%0d busy=%0d required 5 5", hi_cnt, busy_cnt);
    end
    tests++;
    if (bus.stall !== 1'b0 || bus.lo !== 32'd42) begin
      fails++; $display("FAIL stall_after: stall=%0b lo=%h required 0 2a", bus.stall, bus.lo);
    end
    bus.d_use_md = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'd1; bus.b = 32'd1;
    #1;
    tests++;
    if (bus.stall !== 1'b0) begin fails++; $display("FAIL stall_no_dmd: got %0b required 0", bus.stall); end
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_mtlo_unknown;
    logic [31:0] hi_before;
    hi_before = bus.hi;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MTLO; bus.a = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    tests++;
    if (bus.lo !== 32'h1234 || bus.busy !== 1'b0 || bus.hi !== hi_before) begin
      fails++; $display("FAIL mtlo: lo=%h busy=%0b hi=%h required 1234 0 %h", bus.lo, bus.busy, bus.hi, hi_before);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'hF; bus.a = 32'hDEAD; bus.b = 32'd1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NONE;
    tests++;
    if (bus.busy !== 1'b0 || bus.lo !== 32'h1234) begin
      fails++; $display("FAIL unknown_op: busy=%0b lo=%h required 0 1234", bus.busy, bus.lo);
    end
  endtask

  task automatic test_madd;
    int n;
    move_to(MDU_MTHI, 32'd0);
    move_to(MDU_MTLO, 32'd1);
`ifdef MDU_MADD_EN
    run_op(MDU_MADD, 32'd2, 32'd3, n);
    tests++;
    if (n !== 5 || bus.hi !== 32'd0 || bus.lo !== 32'd7) begin
      fails++; $display("FAIL madd: cycles=%0d hi=%h lo=%h required 5 0 7", n, bus.hi, bus.lo);
    end
    run_op(MDU_MADD, 32'hFFFF_FFFF, 32'd8, n);
    tests++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL madd_neg: hi=%h lo=%h required ffffffff ffffffff", bus.hi, bus.lo);
    end
`else
    run_op(MDU_MADD, 32'd2, 32'd3, n);
    tests++;
    if (n !== 0 || bus.hi !== 32'd0 || bus.lo !== 32'd1) begin
      fails++; $display("FAIL madd_disabled: cycles=%0d hi=%h lo=%h required 0 0 1", n, bus.hi, bus.lo);
    end
`endif
  endtask

  initial begin
    bus.start = 1'b0; bus.op = MDU_NONE; bus.a = '0; bus.b = '0; bus.d_use_md = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_reset_mid_op;
    test_stall;
    test_mtlo_unknown;
    test_madd;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
